// File: rtl/regfile_writeback_if.sv
// rtl/regfile_writeback_if.sv - dual-lane write-back request bundle for regfile_writeback
interface regfile_writeback_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            prio_i;
    logic            wb0_valid_i;
    logic [4:0]      wb0_rd_i;
    logic [XLEN-1:0] wb0_data_i;
    logic            wb1_valid_i;
    logic [4:0]      wb1_rd_i;
    logic [XLEN-1:0] wb1_data_i;

    modport master (
        output stall_i, prio_i,
        output wb0_valid_i, wb0_rd_i, wb0_data_i,
        output wb1_valid_i, wb1_rd_i, wb1_data_i
    );

    modport slave (
        input stall_i, prio_i,
        input wb0_valid_i, wb0_rd_i, wb0_data_i,
        input wb1_valid_i, wb1_rd_i, wb1_data_i
    );
endinterface

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - dual-issue register file write-back; REGFILE_BYPASS_EN enables write-first view
module regfile_writeback #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    regfile_writeback_if.slave  wb,
    output logic [XLEN-1:0]     reg_file_o [NREGS-1:0],
    output logic [63:0]         retired_o,
    output logic                conflict_o
);

    logic [XLEN-1:0] regs_q [NREGS-1:1];
    logic [63:0]     retired_q;
    logic            conflict_q;

    logic            we0, we1, same_rd;
    logic            w0_en, w1_en;
    logic [1:0]      retire_inc;

    assign we0     = wb.wb0_valid_i & ~wb.stall_i & (wb.wb0_rd_i != 5'd0);
    assign we1     = wb.wb1_valid_i & ~wb.stall_i & (wb.wb1_rd_i != 5'd0);
    assign same_rd = we0 & we1 & (wb.wb0_rd_i == wb.wb1_rd_i);

    // On a same-rd collision only the younger lane survives: prio_i=0 means lane 1 is younger.
    assign w0_en = we0 & ~(same_rd & ~wb.prio_i);
    assign w1_en = we1 & ~(same_rd &  wb.prio_i);

    assign retire_inc = wb.stall_i ? 2'd0
                      : ({1'b0, wb.wb0_valid_i} + {1'b0, wb.wb1_valid_i});

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int r = 1; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            retired_q  <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (w0_en && (wb.wb0_rd_i == 5'(r))) begin
                    regs_q[r] <= wb.wb0_data_i;
                end else if (w1_en && (wb.wb1_rd_i == 5'(r))) begin
                    regs_q[r] <= wb.wb1_data_i;
                end
            end
            retired_q  <= retired_q + 64'(retire_inc);
            conflict_q <= same_rd;
        end
    end

    always_comb begin
        reg_file_o[0] = '0;
        for (int r = 1; r < NREGS; r++) begin
`ifdef REGFILE_BYPASS_EN
            if (w0_en && (wb.wb0_rd_i == 5'(r))) begin
                reg_file_o[r] = wb.wb0_data_i;
            end else if (w1_en && (wb.wb1_rd_i == 5'(r))) begin
                reg_file_o[r] = wb.wb1_data_i;
            end else begin
                reg_file_o[r] = regs_q[r];
            end
`else
            reg_file_o[r] = regs_q[r];
`endif
        end
    end

    assign retired_o  = retired_q;
    assign conflict_o = conflict_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed plus randomized self-checking bench for regfile_writeback
module tb_regfile_writeback;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [31:0] reg_file_o [31:0];
    logic [63:0] retired_o;
    logic        conflict_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [32];
    logic [63:0] m_retired;
    logic        m_conflict;

    regfile_writeback_if #(.XLEN(32)) wb_if ();

    regfile_writeback #(.XLEN(32), .NREGS(32)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .wb         (wb_if.slave),
        .reg_file_o (reg_file_o),
        .retired_o  (retired_o),
        .conflict_o (conflict_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        m_retired  = '0;
        m_conflict = 1'b0;
    endtask

    task automatic drive_idle();
        wb_if.stall_i     = 1'b0;
        wb_if.prio_i      = 1'b0;
        wb_if.wb0_valid_i = 1'b0;
        wb_if.wb0_rd_i    = '0;
        wb_if.wb0_data_i  = '0;
        wb_if.wb1_valid_i = 1'b0;
        wb_if.wb1_rd_i    = '0;
        wb_if.wb1_data_i  = '0;
    endtask

    task automatic check_state(input string tag);
        for (int r = 0; r < 32; r++) chk($sformatf("%s_x%0d", tag, r), 64'(reg_file_o[r]), 64'(m_regs[r]));
        chk({tag, "_retired"}, retired_o, m_retired);
        chk({tag, "_conflict"}, 64'(conflict_o), 64'(m_conflict));
    endtask

    // One retirement cycle: view check before the edge, reference update, full-state check after.
    task automatic cycle(input string tag, input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                         input logic stall, input logic prio);
        logic        e0, e1, clash;
        logic [31:0] expv;
        @(negedge clk_i);
        wb_if.stall_i = stall;     wb_if.prio_i = prio;
        wb_if.wb0_valid_i = v0;    wb_if.wb0_rd_i = rd0; wb_if.wb0_data_i = d0;
        wb_if.wb1_valid_i = v1;    wb_if.wb1_rd_i = rd1; wb_if.wb1_data_i = d1;
        e0    = v0 && !stall && rd0 != 0;
        e1    = v1 && !stall && rd1 != 0;
        clash = e0 && e1 && rd0 == rd1;
        #1;
        for (int r = 0; r < 32; r++) begin
            expv = m_regs[r];
`ifdef REGFILE_BYPASS_EN
            if (r != 0) begin
                if (clash && rd0 == r)  expv = prio ? d0 : d1;
                else if (e0 && rd0 == r) expv = d0;
                else if (e1 && rd1 == r) expv = d1;
            end
`endif
            chk($sformatf("%s_view_x%0d", tag, r), 64'(reg_file_o[r]), 64'(expv));
        end
        @(posedge clk_i);
        if (!stall) m_retired = m_retired + 64'(v0) + 64'(v1);
        m_conflict = clash;
        if (clash) m_regs[rd0] = prio ? d0 : d1;
        else begin
            if (e0) m_regs[rd0] = d0;
            if (e1) m_regs[rd1] = d1;
        end
        #1;
        drive_idle();
        #1;
        check_state(tag);
    endtask

    initial begin
        logic [4:0] ra, rb;
        drive_idle();
        model_reset();
        rstn_i = 1'b0;
        #12;
        check_state("reset");
        @(negedge clk_i);
        rstn_i = 1'b1;

        cycle("x5_lane0", 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        cycle("x7_prio0", 1'b1, 5'd7, 32'hAAAA_AAAA, 1'b1, 5'd7, 32'h5555_5555, 1'b0, 1'b0);
        chk("x7_prio0_val", 64'(reg_file_o[7]), 64'h5555_5555);
        cycle("idle_clear", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        cycle("x7_prio1", 1'b1, 5'd7, 32'hAAAA_AAAA, 1'b1, 5'd7, 32'h5555_5555, 1'b0, 1'b1);
        chk("x7_prio1_val", 64'(reg_file_o[7]), 64'hAAAA_AAAA);
        cycle("x0_lane1", 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        cycle("x0_both", 1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2, 1'b0, 1'b1);
        cycle("stall", 1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd4, 32'h4444_4444, 1'b1, 1'b0);
        cycle("stall_same", 1'b1, 5'd6, 32'h6, 1'b1, 5'd6, 32'h7, 1'b1, 1'b0);
        cycle("x9_bypass", 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        @(negedge clk_i);
        force dut.retired_q = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk_i);
        #1;
        release dut.retired_q;
        m_retired = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("wrap_preload", retired_o, m_retired);
        cycle("wrap", 1'b1, 5'd10, 32'hA, 1'b1, 5'd11, 32'hB, 1'b0, 1'b0);
        chk("wrap_value", retired_o, 64'd1);

        for (int i = 0; i < 150; i++) begin
            ra = 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            cycle($sformatf("rnd%0d", i), 1'($urandom), ra, $urandom, 1'($urandom), rb, $urandom,
                  ($urandom_range(0, 5) == 0), 1'($urandom));
        end

        for (int r = 1; r < 32; r += 2) begin
            cycle($sformatf("fill%0d", r), 1'b1, 5'(r), 32'h100 + 32'(r),
                  (r < 31), 5'(r + 1), 32'h200 + 32'(r), 1'b0, 1'b0);
        end
        @(negedge clk_i);
        #2;
        rstn_i = 1'b0;
        model_reset();
        #1;
        check_state("midreset");
        @(negedge clk_i);
        rstn_i = 1'b1;
        cycle("post_reset", 1'b1, 5'd2, 32'hCAFE_F00D, 1'b1, 5'd31, 32'h0BAD_CAFE, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back end of the dual-issue register file. It accepts up to two retiring results per cycle, one from each lane, and resolves same-destination conflicts in program order. It exposes the full 32×32 architectural register array that the decode stages read. It also keeps a 64-bit retired-instruction counter and a registered conflict flag for the hazard unit.

## Interface
Parameters:
- XLEN, 32, data width of every register and result.
- NREGS, 32, number of architectural registers; index width is 5.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rstn_i  input  1  asynchronous, active-low reset.
- stall_i  input  1  from hazard unit. When 1, no register write, no count, conflict flag cleared.
- prio_i  input  1  program-order tag of the retiring pair.
  - 0: lane 0 is older.
  - 1: lane 1 is older.
- wb0_valid_i  input  1  lane 0 result valid.
- wb0_rd_i  input  5  lane 0 destination index.
- wb0_data_i  input  XLEN  lane 0 result.
- wb1_valid_i  input  1  lane 1 result valid.
- wb1_rd_i  input  5  lane 1 destination index.
- wb1_data_i  input  XLEN  lane 1 result.
- reg_file_o  output  [XLEN-1:0] × NREGS  architectural register array, unpacked [31:0], read by decode.
- retired_o  output  64  count of valid retirements since reset.
- conflict_o  output  1  registered; 1 for the cycle after both lanes wrote the same non-zero rd.

## Operation
- Lane write enable: weN = wbN_valid_i & ~stall_i & (wbN_rd_i != 0).
- Both enables set with different rd: both registers are written on the same edge.
- Both enables set with equal rd: only the younger lane's data is written.
  - Younger lane is lane 1 when prio_i=0, lane 0 when prio_i=1.
  - conflict_o is set to 1 on that edge; otherwise it is set to 0.
- x0 is hardwired to zero:
  - writes to rd=0 are discarded;
  - reg_file_o[0] is always 0, including under bypass.
- Retired counter:
  - retired_o += wb0_valid_i + wb1_valid_i (0, 1 or 2) per unstalled edge;
  - rd=0 retirements still count;
  - wraps modulo 2^64, so 0xFFFF_FFFF_FFFF_FFFF + 1 = 0 and 0xFFFF_FFFF_FFFF_FFFF + 2 = 1.
- stall_i=1 with valid inputs: inputs are ignored and not buffered. Upstream re-presents them after the stall.
- No internal FSM. State is the register array, retired counter and conflict flag.

## Timing
- Reset (rstn_i low, asynchronous, takes effect immediately, including mid-operation):
  - all registers 0;
  - retired_o = 0;
  - conflict_o = 0.
- Reset release: first write occurs on the first rising edge with rstn_i high.
- Write latency, without bypass: data presented in cycle N is visible on reg_file_o from cycle N+1.
- retired_o and conflict_o have 1-cycle latency: updated on the edge that ends cycle N.
- No handshake: the block is always ready. The valid inputs are sampled every edge, gated by stall_i.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: reg_file_o is a write-first view.
  - For each r≠0, it returns the same-cycle winning write data when that lane's enable is set.
  - Otherwise it returns the stored value.
  - Decode sees the result in cycle N, so zero added latency.
  - Same-rd arbitration and x0 rules apply to the bypass path.
- Undefined: reg_file_o is driven directly from the stored array; a result becomes visible in cycle N+1.
- Stored state, retired_o and conflict_o behave identically in both builds.

## Test plan
- Reset, then lane 0 writes x5=0x1234_5678 (lane 1 invalid).
  - Expect reg_file_o[5]=0x1234_5678 next cycle; retired_o=1.
- Both lanes write x7 in the same cycle, lane 0=0xAAAA_AAAA, lane 1=0x5555_5555.
  - prio_i=0: expect x7=0x5555_5555.
  - Repeat with prio_i=1: expect x7=0xAAAA_AAAA.
  - In both cases expect conflict_o=1 for one cycle and retired_o +2.
- Lane 1 writes x0=0xFFFF_FFFF.
  - Expect reg_file_o[0]=0 and retired_o +1.
- stall_i=1 with both lanes valid (x3, x4).
  - Expect no register change, retired_o unchanged, conflict_o=0.
- Force retired_o to 0xFFFF_FFFF_FFFF_FFFF, then retire two instructions.
  - Expect retired_o=1.
- Assert rstn_i low mid-cycle after writes to x1..x31.
  - Expect all outputs 0 immediately, before the next edge.
- REGFILE_BYPASS_EN build: lane 0 writes x9=0xDEAD_BEEF.
  - Expect reg_file_o[9]=0xDEAD_BEEF in the same cycle.
